mode_counter: RTL
=================

MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: top count value, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter RESET_VAL, default 0: count value after reset, legal range 0..MAX_VAL.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap at the range limits, 1 = hold at the range limits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: count enable; when low, state holds regardless of mode.
REQ-008 SHALL have port mode, input, 2 bits: 00 hold, 01 up, 10 down, 11 load.
REQ-009 SHALL have port load_val, input, WIDTH bits: value taken in load mode.
REQ-010 SHALL have port cnt, output, WIDTH bits: current count, driven directly from a register.
REQ-011 SHALL have port tc_hi, output, 1 bit: combinational flag, cnt==MAX_VAL.
REQ-012 SHALL have port tc_lo, output, 1 bit: combinational flag, cnt==0.
REQ-013 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a limit event.
REQ-014 SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag (REQ-029).
REQ-015 SHALL have port ovf, output, 1 bit: sticky overflow flag (REQ-029).

Function
REQ-016 SHALL update cnt one clk edge after en=1 is sampled together with a non-hold mode; zero-cycle latency to outputs beyond that edge.
REQ-017 SHALL, in up mode with cnt<MAX_VAL, set cnt to cnt+1.
REQ-018 SHALL, in up mode with cnt==MAX_VAL, set cnt to 0 when SATURATE=0, or hold it at MAX_VAL when SATURATE=1.
REQ-019 SHALL, in down mode with cnt>0, set cnt to cnt-1.
REQ-020 SHALL, in down mode with cnt==0, set cnt to MAX_VAL when SATURATE=0, or hold it at 0 when SATURATE=1.
REQ-021 SHALL, in load mode, set cnt to load_val, clamped to MAX_VAL when load_val>MAX_VAL.
REQ-022 SHALL assert wrap for exactly the one cycle after a limit event.
    - A limit event is an up at MAX_VAL or a down at 0, with en=1.
    - wrap asserts in the saturating case as well.
REQ-023 SHALL never assert wrap for a load, a hold, or en=0.
REQ-024 SHALL keep all arithmetic modulo-free inside 0..MAX_VAL; cnt SHALL never hold a value above MAX_VAL.
REQ-025 SHALL keep a held count constant across any number of consecutive en=0 or hold cycles, with wrap low.

Reset
REQ-026 SHALL, on rst_n low at any time (including mid-count), immediately set cnt=RESET_VAL, wrap=0 and ovf=0.
REQ-027 SHALL hold those reset values while rst_n is low.
REQ-028 SHALL perform the first update on the first clk rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when COUNTER_OVF_STICKY_EN is defined, implement ovf with the following rules:
    - ovf sets on any wrap event.
    - ovf clears when clr_ovf=1.
    - If set and clear occur in the same cycle, set wins.
REQ-030 SHALL, when COUNTER_OVF_STICKY_EN is not defined, tie ovf to 0, ignore clr_ovf, and contain no ovf register.

Structure
REQ-031 SHALL take the mode encoding from a typedef, with constants MODE_HOLD, MODE_UP, MODE_DOWN and MODE_LOAD, in shared package counter_pkg.
REQ-032 SHALL be implemented as one flat module; no sub-module.
REQ-033 SHALL check parameter legality at elaboration and fail on an illegal combination.

Verification
REQ-034 SHALL pass the up-wrap case: WIDTH=10, SATURATE=0, load 1021, then up x4 -> cnt 1022, 1023, 0, 1; wrap high only in the cycle after 1023->0.
REQ-035 SHALL pass the down-saturate case: SATURATE=1, load 2, then down x4 -> cnt 1, 0, 0, 0; wrap pulses once per down-at-0 cycle (twice in total).
REQ-036 SHALL pass the clamp case: MAX_VAL=600, load_val=1000 -> cnt=600 and tc_hi=1; one further up -> cnt=0.
REQ-037 SHALL pass the hold/enable case: cnt=7 with mode=up and en=0 for 5 cycles -> cnt stays 7 and wrap stays 0.
REQ-038 SHALL pass the mid-operation reset case: counting up at cnt=500, rst_n pulsed low between edges -> cnt=RESET_VAL (0) immediately, before the next edge.
REQ-039 SHALL pass the sticky-flag case (COUNTER_OVF_STICKY_EN defined): wrap with clr_ovf=1 in the same cycle -> ovf=1; a later clr_ovf alone -> ovf=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the mode counter: the two-bit mode encoding.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/mode_counter.sv
// Up/down/load counter with wrap or saturate at 0..MAX_VAL and a limit-event pulse.
// Optional sticky overflow flag enabled by defining COUNTER_OVF_STICKY_EN.
module mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 10,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RESET_VAL = 64'd0,
    parameter int unsigned     SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc_hi,
    output logic             tc_lo,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > 32 || MAX_VAL < 64'd1 ||
        MAX_VAL > ((64'd1 << WIDTH) - 64'd1) || RESET_VAL > MAX_VAL ||
        SATURATE > 1) begin : g_param_check
        $error("mode_counter: illegal parameter combination");
    end

    localparam logic [WIDTH-1:0] MAX_C   = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_C = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    mode_e mode_q;
    logic  at_max;
    logic  at_min;
    logic  limit_evt;

    assign mode_q = mode_e'(mode);
    assign at_max = (cnt == MAX_C);
    assign at_min = (cnt == '0);
    assign tc_hi  = at_max;
    assign tc_lo  = at_min;

    // A limit event is an enabled step past either end, whether it wraps or saturates.
    assign limit_evt = en && ((mode_q == MODE_UP && at_max) ||
                              (mode_q == MODE_DOWN && at_min));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RESET_C;
            wrap <= 1'b0;
        end else begin
            wrap <= limit_evt;
            if (en) begin
                case (mode_q)
                    MODE_UP: begin
                        if (!at_max)
                            cnt <= cnt + ONE;
                        else if (SATURATE == 0)
                            cnt <= '0;
                    end
                    MODE_DOWN: begin
                        if (!at_min)
                            cnt <= cnt - ONE;
                        else if (SATURATE == 0)
                            cnt <= MAX_C;
                    end
                    MODE_LOAD: cnt <= (load_val > MAX_C) ? MAX_C : load_val;
                    default:   cnt <= cnt;
                endcase
            end
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    // Set takes priority over clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (limit_evt)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign ovf            = 1'b0;
`endif

endmodule
